// File: rtl/charrua_ctrl.sv
// rtl/charrua_ctrl.sv - fetch/decode/execute sequencer driving an external combinational alu
module charrua_ctrl #(
  parameter int BITS   = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [BITS-1:0]   mem_wdata,
  input  logic [BITS-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [4:0]        alu_opcode,
  output logic [BITS-1:0]   alu_a,
  output logic [BITS-1:0]   alu_acc,
  input  logic [BITS-1:0]   alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPERAND = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [4:0] OP_STORE = 5'b00001;
  localparam logic [4:0] OP_JMP   = 5'b01000;
  localparam logic [4:0] OP_JZ    = 5'b01001;
  localparam logic [4:0] OP_JN    = 5'b01010;
  localparam logic [4:0] OP_NOT   = 5'b01111;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [BITS-1:0]   ir_q, ir_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [BITS-1:0]   opnd_q, opnd_d;
  // live_q stays low for the first cycle after reset so an ack belonging to
  // a request dropped by reset can never complete the fresh fetch.
  logic              live_q, live_d;

  logic [4:0]        opcode;
  logic [ADDR_W-1:0] field_addr;
  logic [BITS-1:0]   field_zext;
  logic              req_rd, req_wr, acked;

  assign opcode     = ir_q[15:11];
  assign field_addr = ir_q[ADDR_W-1:0];
  assign field_zext = {{(BITS-11){1'b0}}, ir_q[10:0]};

  assign req_rd = live_q && ((state_q == S_FETCH) || (state_q == S_OPERAND));
  assign req_wr = live_q && (state_q == S_WRITE);
  assign acked  = mem_ack && (req_rd || req_wr);

  assign mem_rd     = req_rd;
  assign mem_wr     = req_wr;
  assign mem_addr   = (state_q == S_FETCH) ? pc_q : field_addr;
  assign mem_wdata  = acc_q;
  assign alu_opcode = (state_q == S_EXEC) ? opcode : 5'd0;
  assign alu_a      = opnd_q;
  assign alu_acc    = acc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);

  // Next-state and datapath update for the instruction sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    live_d  = 1'b1;
    case (state_q)
      S_FETCH: begin
        if (acked) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_STORE: state_d = S_WRITE;
          OP_JMP:   pc_d = field_addr;
          OP_JZ:    if (acc_q == '0) pc_d = field_addr;
          OP_JN:    if (acc_q[BITS-1]) pc_d = field_addr;
          OP_HALT:  state_d = S_HALT;
          OP_NOT:   state_d = S_EXEC;
          5'b00010, 5'b00100, 5'b00110,
          5'b10000, 5'b10010, 5'b10100: state_d = S_OPERAND;
          5'b00011, 5'b00101, 5'b00111, 5'b10001,
          5'b10011, 5'b10101, 5'b10110, 5'b10111: begin
            opnd_d  = field_zext;
            state_d = S_EXEC;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_OPERAND: begin
        if (acked) begin
          opnd_d  = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d   = alu_result;
        state_d = S_FETCH;
      end
      S_WRITE: begin
        if (acked) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_charrua_ctrl.sv
// tb/tb_charrua_ctrl.sv - scoreboard bench for charrua_ctrl with an ISA-level reference model
module tb_charrua_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] mem_addr, pc;
  logic        mem_rd, mem_wr, mem_ack = 1'b0, halted;
  logic [15:0] mem_wdata, mem_rdata = 16'h0, alu_a, alu_acc, alu_result;
  logic [4:0]  alu_opcode;

  logic [3:0]  mem_addr4, pc4;
  logic        rd4, wr4, ack4 = 1'b0, halted4;
  logic [15:0] wdata4, rdata4 = 16'h0, alu_a4, alu_acc4, alu_result4;
  logic [4:0]  alu_opcode4;

  typedef struct packed { logic wr; logic [10:0] addr; logic [15:0] data; } txn_t;
  txn_t exp_q[$];

  logic [15:0] mem [0:2047];
  logic [15:0] img [0:2047];
  logic [15:0] mdl [0:2047];
  logic [15:0] mem4 [0:15];

  int checks = 0, errors = 0;
  int wcnt = -1;
  bit resp_en = 0, rand_wait = 0, store_wait = 0, mon_en = 0, store_chk = 0, chk4 = 0;
  int wr_hold = 0, hold_bad = 0, prev4 = -1;
  bit drop_pend = 0;

  always #5 clk = ~clk;

  charrua_ctrl #(.BITS(16), .ADDR_W(11)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_acc(alu_acc), .alu_result(alu_result),
    .pc(pc), .halted(halted));

  charrua_ctrl #(.BITS(16), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr4), .mem_rd(rd4), .mem_wr(wr4),
    .mem_wdata(wdata4), .mem_rdata(rdata4), .mem_ack(ack4),
    .alu_opcode(alu_opcode4), .alu_a(alu_a4), .alu_acc(alu_acc4), .alu_result(alu_result4),
    .pc(pc4), .halted(halted4));

  // Bench-side alu; undefined opcodes scramble acc so a wrongly executed opcode shows up.
  function automatic logic [15:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] acc);
    case (op)
      5'd0:        return acc;
      5'd2, 5'd3:  return a;
      5'd4, 5'd5:  return acc + a;
      5'd6, 5'd7:  return acc - a;
      5'd16, 5'd17: return acc & a;
      5'd18, 5'd19: return acc | a;
      5'd20, 5'd21: return acc ^ a;
      5'd22:       return acc << a;
      5'd23:       return acc >> a;
      5'd15:       return ~acc;
      default:     return acc ^ 16'h5A5A;
    endcase
  endfunction

  always_comb alu_result  = alu_f(alu_opcode, alu_a, alu_acc);
  always_comb alu_result4 = alu_f(alu_opcode4, alu_a4, alu_acc4);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_mem_op(input logic [4:0] op);
    return op inside {5'b00010, 5'b00100, 5'b00110, 5'b10000, 5'b10010, 5'b10100};
  endfunction
  function automatic bit is_imm_op(input logic [4:0] op);
    return op inside {5'b00011, 5'b00101, 5'b00111, 5'b10001, 5'b10011, 5'b10101, 5'b10110, 5'b10111};
  endfunction

  // Instruction-level interpreter: produces the expected memory transaction stream.
  task automatic model_run(output logic [15:0] macc, output logic [10:0] mpc);
    logic [10:0] p = 11'h0;
    logic [15:0] acc = 16'h0, ins;
    logic [4:0]  op;
    logic [10:0] f;
    bit done = 0;
    for (int i = 0; i < 2048; i++) mdl[i] = img[i];
    for (int s = 0; s < 500 && !done; s++) begin
      ins = mdl[p];
      exp_q.push_back('{1'b0, p, 16'h0});
      p  = p + 11'd1;
      op = ins[15:11];
      f  = ins[10:0];
      if (op == 5'd1) begin
        exp_q.push_back('{1'b1, f, acc});
        mdl[f] = acc;
      end else if (op == 5'd8) p = f;
      else if (op == 5'd9) begin if (acc == 16'h0) p = f; end
      else if (op == 5'd10) begin if (acc[15]) p = f; end
      else if (op == 5'd31) done = 1;
      else if (is_mem_op(op)) begin
        exp_q.push_back('{1'b0, f, 16'h0});
        acc = alu_f(op, mdl[f], acc);
      end else if (is_imm_op(op)) acc = alu_f(op, {5'b0, f}, acc);
      else if (op == 5'd15) acc = alu_f(op, 16'h0, acc);
    end
    macc = acc;
    mpc  = p;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 2048; i++) img[i] = 16'h0;
  endtask

  // Random loop-free program: forward jumps only, data in 0x100..0x10F.
  task automatic gen_random(input int n);
    logic [4:0] mops [6] = '{5'b00010, 5'b00100, 5'b00110, 5'b10000, 5'b10010, 5'b10100};
    logic [4:0] iops [8] = '{5'b00011, 5'b00101, 5'b00111, 5'b10001, 5'b10011, 5'b10101, 5'b10110, 5'b10111};
    logic [4:0] uops [3] = '{5'b11010, 5'b01100, 5'b11000};
    logic [10:0] d, t;
    clear_img();
    for (int i = 0; i < 16; i++) img[256 + i] = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      d = 11'(256 + $urandom_range(0, 15));
      t = 11'($urandom_range(i + 1, n));
      case ($urandom_range(0, 9))
        0: img[i] = 16'h0000;
        1: img[i] = {5'b00001, d};
        2: img[i] = {5'b01000, t};
        3: img[i] = {5'b01001, t};
        4: img[i] = {5'b01010, t};
        5: img[i] = {mops[$urandom_range(0, 5)], d};
        6, 7: img[i] = {iops[$urandom_range(0, 7)], 11'($urandom_range(0, 2047))};
        8: img[i] = {5'b01111, 11'h0};
        default: img[i] = {uops[$urandom_range(0, 2)], 11'h0};
      endcase
    end
    img[n] = 16'hF800;
  endtask

  task automatic run_program(input bit rw, input bit sw, input bit cc,
                             input logic [15:0] c_acc, input logic [10:0] c_pc);
    logic [15:0] macc;
    logic [10:0] mpc;
    bit any = 0;
    @(negedge clk);
    rst = 1'b1; resp_en = 0; mon_en = 0; mem_ack = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2048; i++) mem[i] = img[i];
    model_run(macc, mpc);
    rand_wait = rw; store_wait = sw;
    @(negedge clk);
    rst = 1'b0; resp_en = 1; mon_en = 1;
    for (int c = 0; c < 4000 && !halted; c++) @(negedge clk);
    #3;
    check("halted", halted, 1);
    check("queue_drained", exp_q.size(), 0);
    check("final_acc", alu_acc, macc);
    check("final_pc", pc, mpc);
    if (cc) begin
      check("const_acc", alu_acc, c_acc);
      check("const_pc", pc, c_pc);
    end
    repeat (5) begin
      @(negedge clk); #1;
      if (mem_rd || mem_wr) any = 1;
    end
    check("no_req_after_halt", any, 0);
    resp_en = 0; mon_en = 0;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  // Memory responder: random or fixed wait states, plus spurious acks while idle.
  initial begin
    forever begin
      @(negedge clk);
      if (!resp_en) wcnt = -1;
      else begin
        mem_ack = 1'b0;
        if (mem_rd || mem_wr) begin
          if (wcnt < 0) wcnt = (mem_wr && store_wait) ? 5 : (rand_wait ? $urandom_range(0, 3) : 0);
          if (wcnt == 0) begin
            if (mem_wr) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem[mem_addr];
            mem_ack = 1'b1;
            wcnt = -1;
          end else wcnt--;
        end else if ($urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Zero-wait memory for the narrow-address instance.
  initial begin
    forever begin
      @(negedge clk);
      ack4 = rd4 || wr4;
      if (rd4) rdata4 = mem4[mem_addr4];
    end
  end

  // Monitor: pops the scoreboard on every completed transaction.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk); #2;
      if (mon_en && mem_ack && (mem_rd || mem_wr)) begin
        if (exp_q.size() == 0) check("txn_unexpected", {mem_wr, mem_addr}, 0);
        else begin
          t = exp_q.pop_front();
          check("txn", {mem_wr, mem_rd, alu_opcode, mem_addr, mem_wr ? mem_wdata : 16'h0},
                {t.wr, ~t.wr, 5'd0, t.addr, t.wr ? t.data : 16'h0});
        end
      end
      if (store_chk) begin
        if (drop_pend) begin
          check("store_drop", mem_wr, 0);
          drop_pend = 0;
        end
        if (mem_wr) begin
          if (mem_addr != 11'h020 || mem_wdata != 16'hBEEF) hold_bad++;
          if (mem_ack) begin
            drop_pend = 1;
            check("store_hold_cycles", wr_hold, 5);
          end else wr_hold++;
        end
      end
      if (chk4 && ack4 && rd4) begin
        if (prev4 >= 0) check("addr4_seq", mem_addr4, (prev4 + 1) % 16);
        if (prev4 >= 0 && mem_addr4 >= 4'd2) check("acc4_kept", alu_acc4, 16'h0123);
        prev4 = int'(mem_addr4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    mem4[0] = 16'h1923;
    mem4[1] = 16'hD000;

    // Reset behaviour: drop mid-request, ignore a late ack.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("first_fetch_rd", mem_rd, 1);
    check("first_fetch_addr", mem_addr, 0);
    #2 rst = 1'b1;
    #1;
    check("reset_drops_rd", {mem_rd, mem_wr, halted}, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk); #1;
    check("post_reset_req", {mem_rd, mem_addr}, {1'b1, 11'h0});
    check("post_reset_pc_acc", {pc, alu_acc}, 0);

    clear_img();
    img[0] = 16'h1805; img[1] = 16'h2010; img[2] = 16'hF800; img[16] = 16'h0007;
    run_program(1, 0, 1, 16'h000C, 11'd3);

    clear_img();
    img[0] = 16'h4840; img[64] = 16'hF800;
    run_program(0, 0, 1, 16'h0000, 11'h041);
    clear_img();
    img[0] = 16'h1801; img[1] = 16'h4840; img[2] = 16'hF800; img[64] = 16'hF800;
    run_program(1, 0, 1, 16'h0001, 11'd3);
    clear_img();
    img[0] = 16'h1801; img[1] = 16'hB00F; img[2] = 16'h5040; img[3] = 16'hF800;
    img[64] = 16'h1877; img[65] = 16'hF800;
    run_program(1, 0, 1, 16'h0077, 11'h042);

    clear_img();
    img[0] = 16'h1030; img[48] = 16'hBEEF; img[1] = 16'h0820; img[2] = 16'hF800;
    store_chk = 1; wr_hold = 0; hold_bad = 0; drop_pend = 0;
    run_program(0, 1, 1, 16'hBEEF, 11'd3);
    store_chk = 0;
    check("store_stable", hold_bad, 0);
    check("store_mem", mem[32], 16'hBEEF);

    clear_img();
    img[0] = 16'h3801; img[1] = 16'hF800;
    run_program(1, 0, 1, 16'hFFFF, 11'd2);
    clear_img();
    img[0] = 16'h1031; img[49] = 16'h0F0F; img[1] = 16'hB004; img[2] = 16'hF800;
    run_program(1, 0, 1, 16'hF0F0, 11'd3);

    prev4 = -1; chk4 = 1;
    repeat (150) @(negedge clk);
    chk4 = 0;

    for (int r = 0; r < 12; r++) begin
      gen_random(24);
      run_program(1, 0, 0, 16'h0, 11'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
